bomb_controller: RTL and testbench

- Sequences the single-bomb resource for the player: placement, fuse countdown, blast scan, blast hold, then return to idle.
- Sits between the debounced centre button / bomberman position and two consumers:
  - the tile-map block, which clears breakable walls through a req/ack handshake;
  - the bomb and explosion sprite renderers, which read this block's position and extent outputs to drive their rgb enables.
- Also flags a player hit, which feeds game_over.

---
 rtl/bomberman_pkg.sv | 27 ++
 rtl/blast_scanner.sv | 137 +++++++++++++
 rtl/bomb_controller.sv | 141 ++++++++++++++
 tb/tb_bomb_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and grid constants for the bomberman game blocks.
// Tile mapping helper converts a sprite top-left pixel to its centre tile.
package bomberman_pkg;

  typedef enum logic [1:0] {IDLE, FUSE, SCAN, BLAST} state_e;
  typedef enum logic [1:0] {DIR_L, DIR_R, DIR_U, DIR_D} dir_e;

  localparam int TILE_SHIFT = 4;
  localparam int GRID_COLS  = 40;
  localparam int GRID_ROWS  = 30;

  // Pixel coordinates stay below 640, so the +8 never overflows 10 bits.
  function automatic logic [5:0] pix_to_tile(input logic [9:0] pix);
    logic [9:0] centre;
    centre = pix + 10'd8;
    return centre[9:TILE_SHIFT];
  endfunction

  function automatic dir_e next_dir(input dir_e dir);
    case (dir)
      DIR_L:   return DIR_R;
      DIR_R:   return DIR_U;
      default: return DIR_D;
    endcase
  endfunction

endpackage

// File: rtl/blast_scanner.sv
// Walks the blast outward L, R, U, D from the origin, issuing one tile-clear
// request at a time and recording how far each arm reaches.
module blast_scanner
  import bomberman_pkg::*;
#(
  parameter int RANGE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       flush_i,
  input  logic [5:0] org_tx_i,
  input  logic [4:0] org_ty_i,
  output logic       clr_req_o,
  output logic [5:0] clr_tx_o,
  output logic [4:0] clr_ty_o,
  input  logic       clr_ack_i,
  input  logic       clr_hard_i,
  input  logic       clr_hit_i,
  output logic [2:0] ext_l_o,
  output logic [2:0] ext_r_o,
  output logic [2:0] ext_u_o,
  output logic [2:0] ext_d_o,
  output logic       done_o
);

  localparam logic signed [7:0] COLS_S = 8'(GRID_COLS);
  localparam logic signed [7:0] ROWS_S = 8'(GRID_ROWS);

  logic            busy_q, busy_d;
  dir_e            dir_q, dir_d;
  logic [2:0]      k_q, k_d;
  logic            req_q, req_d;
  logic [5:0]      tx_q, tx_d;
  logic [4:0]      ty_q, ty_d;
  logic [3:0][2:0] ext_q, ext_d;
  logic            done_q, done_d;
  logic            dir_end;

  logic signed [7:0] col_s, row_s, step_s;
  logic              off_grid;

  always_comb begin
    step_s = $signed({5'd0, k_q});
    col_s  = $signed({2'd0, org_tx_i});
    row_s  = $signed({3'd0, org_ty_i});
    case (dir_q)
      DIR_L:   col_s = col_s - step_s;
      DIR_R:   col_s = col_s + step_s;
      DIR_U:   row_s = row_s - step_s;
      default: row_s = row_s + step_s;
    endcase
    off_grid = (col_s < 8'sd0) || (col_s >= COLS_S) ||
               (row_s < 8'sd0) || (row_s >= ROWS_S);
  end

  always_comb begin
    busy_d  = busy_q;
    dir_d   = dir_q;
    k_d     = k_q;
    req_d   = req_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    ext_d   = ext_q;
    done_d  = 1'b0;
    dir_end = 1'b0;
    if (flush_i) ext_d = '0;
    if (start_i) begin
      busy_d = 1'b1;
      dir_d  = DIR_L;
      k_d    = 3'd1;
      req_d  = 1'b0;
      ext_d  = '0;
    end else if (busy_q) begin
      if (!req_q) begin
        if (off_grid) begin
          dir_end = 1'b1;
        end else begin
          req_d = 1'b1;
          tx_d  = col_s[5:0];
          ty_d  = row_s[4:0];
        end
      end else if (clr_ack_i) begin
        req_d = 1'b0;
        // Hard wins over hit when the map reports both.
        if (clr_hard_i) begin
          dir_end = 1'b1;
        end else begin
          ext_d[dir_q] = k_q;
          if (clr_hit_i || k_q == 3'(RANGE)) dir_end = 1'b1;
          else                               k_d = k_q + 3'd1;
        end
      end
    end
    if (dir_end) begin
      k_d = 3'd1;
      if (dir_q == DIR_D) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        dir_d = next_dir(dir_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      dir_q  <= DIR_L;
      k_q    <= 3'd1;
      req_q  <= 1'b0;
      tx_q   <= '0;
      ty_q   <= '0;
      ext_q  <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      dir_q  <= dir_d;
      k_q    <= k_d;
      req_q  <= req_d;
      tx_q   <= tx_d;
      ty_q   <= ty_d;
      ext_q  <= ext_d;
      done_q <= done_d;
    end
  end

  assign clr_req_o = req_q;
  assign clr_tx_o  = tx_q;
  assign clr_ty_o  = ty_q;
  assign ext_l_o   = ext_q[DIR_L];
  assign ext_r_o   = ext_q[DIR_R];
  assign ext_u_o   = ext_q[DIR_U];
  assign ext_d_o   = ext_q[DIR_D];
  assign done_o    = done_q;

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb sequencer: place, fuse, blast scan, blast hold, idle.
// Define REMOTE_DETONATE_EN to let a second press during the fuse detonate early.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int FUSE_CYCLES  = 300_000_000,
  parameter int BLAST_CYCLES = 50_000_000,
  parameter int CNT_W        = 29,
  parameter int RANGE        = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_req,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       bomb_active,
  output logic [5:0] bomb_tx,
  output logic [4:0] bomb_ty,
  output logic       blast_active,
  output logic [2:0] ext_l,
  output logic [2:0] ext_r,
  output logic [2:0] ext_u,
  output logic [2:0] ext_d,
  output logic       clr_req,
  output logic [5:0] clr_tx,
  output logic [4:0] clr_ty,
  input  logic       clr_ack,
  input  logic       clr_hard,
  input  logic       clr_hit,
  output logic       player_hit
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [5:0]       bomb_tx_q, bomb_tx_d;
  logic [4:0]       bomb_ty_q, bomb_ty_d;

  logic [5:0] p_tx, p_ty;
  logic       fuse_last, blast_last, fuse_end, scan_start, scan_done, blast_end;
  logic       in_blast;

  assign p_tx       = pix_to_tile(b_x);
  assign p_ty       = pix_to_tile(b_y);
  assign fuse_last  = (timer_q == CNT_W'(FUSE_CYCLES - 1));
  assign blast_last = (timer_q == CNT_W'(BLAST_CYCLES - 1));
`ifdef REMOTE_DETONATE_EN
  assign fuse_end   = fuse_last || place_req;
`else
  assign fuse_end   = fuse_last;
`endif
  assign scan_start = (state_q == FUSE) && fuse_end;
  assign blast_end  = (state_q == BLAST) && blast_last;

  blast_scanner #(.RANGE(RANGE)) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .start_i    (scan_start),
    .flush_i    (blast_end),
    .org_tx_i   (bomb_tx_q),
    .org_ty_i   (bomb_ty_q),
    .clr_req_o  (clr_req),
    .clr_tx_o   (clr_tx),
    .clr_ty_o   (clr_ty),
    .clr_ack_i  (clr_ack),
    .clr_hard_i (clr_hard),
    .clr_hit_i  (clr_hit),
    .ext_l_o    (ext_l),
    .ext_r_o    (ext_r),
    .ext_u_o    (ext_u),
    .ext_d_o    (ext_d),
    .done_o     (scan_done)
  );

  // Each arm test includes distance 0, so the bomb tile itself always hits.
  assign in_blast =
      ((p_ty == {1'b0, bomb_ty_q}) && (p_tx <= bomb_tx_q) && ((bomb_tx_q - p_tx) <= {3'd0, ext_l})) ||
      ((p_ty == {1'b0, bomb_ty_q}) && (p_tx >= bomb_tx_q) && ((p_tx - bomb_tx_q) <= {3'd0, ext_r})) ||
      ((p_tx == bomb_tx_q) && (p_ty <= {1'b0, bomb_ty_q}) && (({1'b0, bomb_ty_q} - p_ty) <= {3'd0, ext_u})) ||
      ((p_tx == bomb_tx_q) && (p_ty >= {1'b0, bomb_ty_q}) && ((p_ty - {1'b0, bomb_ty_q}) <= {3'd0, ext_d}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bomb_tx_q <= '0;
      bomb_ty_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bomb_tx_q <= bomb_tx_d;
      bomb_ty_q <= bomb_ty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bomb_tx_d = bomb_tx_q;
    bomb_ty_d = bomb_ty_q;
    case (state_q)
      IDLE: if (place_req) begin
        state_d   = FUSE;
        timer_d   = '0;
        bomb_tx_d = p_tx;
        bomb_ty_d = p_ty[4:0];
      end
      FUSE: begin
        timer_d = timer_q + CNT_W'(1);
        if (fuse_end) state_d = SCAN;
      end
      SCAN: if (scan_done) begin
        state_d = BLAST;
        timer_d = '0;
      end
      BLAST: begin
        timer_d = timer_q + CNT_W'(1);
        if (blast_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bomb_active  = 1'b0;
    blast_active = 1'b0;
    player_hit   = 1'b0;
    case (state_q)
      FUSE, SCAN: bomb_active = 1'b1;
      BLAST: begin
        bomb_active  = 1'b1;
        blast_active = 1'b1;
        player_hit   = (timer_q == '0) && in_blast;
      end
      default: ;
    endcase
  end

  assign bomb_tx = bomb_tx_q;
  assign bomb_ty = bomb_ty_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed and randomized bench for bomb_controller against a tile-map
// reference model of the blast walk, player hit and phase timing.
module tb_bomb_controller;

  localparam int FUSE  = 10;
  localparam int BLAST = 5;
  localparam int RNG   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       place_req;
  logic [9:0] b_x, b_y;
  logic       bomb_active, blast_active, clr_req, player_hit;
  logic [5:0] bomb_tx, clr_tx;
  logic [4:0] bomb_ty, clr_ty;
  logic [2:0] ext_l, ext_r, ext_u, ext_d;
  logic       clr_ack, clr_hard, clr_hit;

  always #5 clk = ~clk;

  bomb_controller #(
    .FUSE_CYCLES(FUSE), .BLAST_CYCLES(BLAST), .CNT_W(29), .RANGE(RNG)
  ) dut (
    .clk(clk), .reset(reset), .place_req(place_req), .b_x(b_x), .b_y(b_y),
    .bomb_active(bomb_active), .bomb_tx(bomb_tx), .bomb_ty(bomb_ty),
    .blast_active(blast_active), .ext_l(ext_l), .ext_r(ext_r), .ext_u(ext_u),
    .ext_d(ext_d), .clr_req(clr_req), .clr_tx(clr_tx), .clr_ty(clr_ty),
    .clr_ack(clr_ack), .clr_hard(clr_hard), .clr_hit(clr_hit),
    .player_hit(player_hit)
  );

  int checks   = 0;
  int failures = 0;
  int map_m [40][30];   // 0 empty, 1 breakable, 2 hard, 3 both flags
  int got_q[$];
  int exp_q[$];
  int exp_ext[4];
  int ack_dly = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tile(input int p);
    return (p + 8) / 16;
  endfunction

  task automatic clear_map();
    for (int c = 0; c < 40; c++)
      for (int r = 0; r < 30; r++) map_m[c][r] = 0;
  endtask

  // Expected request order and arm lengths, straight from the blast rules.
  task automatic model_scan(input int tx, input int ty);
    int dx[4] = '{-1, 1, 0, 0};
    int dy[4] = '{0, 0, -1, 1};
    int c, r;
    exp_q.delete();
    for (int d = 0; d < 4; d++) begin
      exp_ext[d] = 0;
      for (int k = 1; k <= RNG; k++) begin
        c = tx + dx[d] * k;
        r = ty + dy[d] * k;
        if (c < 0 || c >= 40 || r < 0 || r >= 30) break;
        exp_q.push_back(c * 32 + r);
        if (map_m[c][r] >= 2) break;
        exp_ext[d] = k;
        if (map_m[c][r] == 1) break;
      end
    end
  endtask

  // Tile-map responder with programmable ack delay and stray acks.
  initial begin
    int wcnt, c, r, v;
    clr_ack = 1'b0; clr_hard = 1'b0; clr_hit = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (clr_ack) begin
        clr_ack = 1'b0; clr_hard = 1'b0; clr_hit = 1'b0;
      end else if (clr_req) begin
        if (wcnt >= ack_dly) begin
          c = int'(clr_tx); r = int'(clr_ty);
          v = (c < 40 && r < 30) ? map_m[c][r] : 2;
          got_q.push_back(c * 32 + r);
          clr_ack  = 1'b1;
          clr_hard = (v >= 2);
          clr_hit  = (v == 1 || v == 3);
          if (v == 1) map_m[c][r] = 0;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          clr_ack = 1'b1; clr_hit = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_bomb(input int bx, input int by, input int px, input int py,
                          input bit early, input bit late, output int lat);
    int  btx, bty, ptx, pty, nhit, blast_n, ehit, t;
    bit  finished;
    btx = tile(bx); bty = tile(by); ptx = tile(px); pty = tile(py);
    model_scan(btx, bty);
    ehit = ((ptx == btx) && (pty == bty)) ||
           ((pty == bty) && (ptx < btx) && (btx - ptx <= exp_ext[0])) ||
           ((pty == bty) && (ptx > btx) && (ptx - btx <= exp_ext[1])) ||
           ((ptx == btx) && (pty < bty) && (bty - pty <= exp_ext[2])) ||
           ((ptx == btx) && (pty > bty) && (pty - bty <= exp_ext[3])) ? 1 : 0;
    got_q.delete();
    @(negedge clk);
    b_x = 10'(bx); b_y = 10'(by); place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0; b_x = 10'(px); b_y = 10'(py);
    chk("bomb_active_rise", bomb_active, 1);
    chk("bomb_tx", bomb_tx, btx);
    chk("bomb_ty", bomb_ty, bty);
    lat = -1; nhit = 0; blast_n = 0; finished = 1'b0;
    for (t = 0; t < 400; t++) begin
      if (player_hit) nhit++;
      if (lat < 0 && clr_req) lat = t;
      if (early && t == 3) begin place_req = 1'b1; b_x = 10'(px + 48); end
      if (early && t == 4) begin place_req = 1'b0; b_x = 10'(px); end
      if (blast_active) begin
        blast_n++;
        if (blast_n == 1) begin
          chk("ext_l", ext_l, exp_ext[0]);
          chk("ext_r", ext_r, exp_ext[1]);
          chk("ext_u", ext_u, exp_ext[2]);
          chk("ext_d", ext_d, exp_ext[3]);
          chk("bomb_tx_held", bomb_tx, btx);
          chk("req_count", got_q.size(), exp_q.size());
          for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("req%0d_tile", i), got_q[i], exp_q[i]);
        end
        if (late && blast_n == BLAST) begin
          place_req = 1'b1; b_x = 10'd200; b_y = 10'd200;
        end
      end else if (blast_n > 0) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("bomb_completed", {31'd0, finished}, 1);
    chk("blast_len", blast_n, BLAST);
    chk("player_hit_count", nhit, ehit);
    chk("idle_bomb_active", bomb_active, 0);
    chk("idle_ext", {ext_l, ext_r, ext_u, ext_d}, 0);
    if (!early) chk("fuse_quiet", (lat >= FUSE) ? 1 : 0, 1);
    if (late) begin
      @(negedge clk);
      place_req = 1'b0;
      chk("late_press_then_idle_press", bomb_active, 1);
      chk("late_bomb_tx", bomb_tx, tile(200));
    end
  endtask

  task automatic drain();
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!bomb_active) begin done_ok = 1'b1; break; end
    end
    chk("drain_done", {31'd0, done_ok}, 1);
  endtask

  initial begin
    int lat1, lat2, lat, bx, by, px, py, ox, oy, v;
    bit seen;
    reset = 1'b0; place_req = 1'b0; b_x = '0; b_y = '0;
    clear_map();
    repeat (3) @(negedge clk);
    chk("rst_bomb_active", bomb_active, 0);
    chk("rst_blast_active", blast_active, 0);
    chk("rst_clr_req", clr_req, 0);
    chk("rst_player_hit", player_hit, 0);
    chk("rst_ext", {ext_l, ext_r, ext_u, ext_d}, 0);
    chk("rst_bomb_tile", {bomb_tx, bomb_ty}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_no_bomb", bomb_active, 0);

    // Open map, player on the down arm.
    run_bomb(100, 100, 96, 112, 1'b0, 1'b0, lat1);
    chk("scan_start_window", (lat1 >= FUSE && lat1 <= FUSE + 4) ? 1 : 0, 1);
    // Corner bomb, player far away.
    run_bomb(0, 0, 128, 128, 1'b0, 1'b0, lat);
    // Hard wall left, breakable right; player (8,8) outside.
    map_m[5][6] = 2; map_m[7][6] = 1;
    run_bomb(100, 100, 128, 128, 1'b0, 1'b0, lat);
    clear_map();
    // Second press on fuse cycle 3.
    run_bomb(100, 100, 96, 112, 1'b1, 1'b0, lat2);
`ifdef REMOTE_DETONATE_EN
    chk("remote_detonate_latency", lat2, lat1 - (FUSE - 4));
`else
    chk("fuse_press_ignored", lat2, lat1);
`endif
    // Press in last BLAST cycle ignored, first IDLE cycle accepted.
    run_bomb(300, 200, 300, 200, 1'b0, 1'b1, lat);
    drain();

    // Reset while a request is outstanding.
    ack_dly = 3;
    @(negedge clk); b_x = 10'd100; b_y = 10'd100; place_req = 1'b1;
    @(negedge clk); place_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (clr_req) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("req_before_reset", {31'd0, seen}, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_clr_req", clr_req, 0);
    chk("async_rst_bomb_active", bomb_active, 0);
    chk("async_rst_ext", {ext_l, ext_r, ext_u, ext_d}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ack_dly = 0;
    run_bomb(100, 100, 96, 112, 1'b0, 1'b0, lat);

    // Randomized maps, positions and ack delays.
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < 40; c++)
        for (int r = 0; r < 30; r++) begin
          v = int'($urandom_range(0, 7));
          map_m[c][r] = (v < 4) ? 0 : (v < 6) ? 1 : (v == 6) ? 2 : 3;
        end
      ack_dly = int'($urandom_range(0, 3));
      bx = int'($urandom_range(0, 639));
      by = int'($urandom_range(0, 479));
      ox = int'($urandom_range(0, 6)) - 3;
      oy = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 1) == 1) oy = 0; else ox = 0;
      px = (tile(bx) + ox) * 16;
      py = (tile(by) + oy) * 16;
      if (px < 0) px = 0;
      if (px > 639) px = 624;
      if (py < 0) py = 0;
      if (py > 479) py = 464;
      run_bomb(bx, by, px, py, 1'b0, 1'b0, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
